// File: rtl/vga_sync_timing_detector.sv
// vga_sync_timing_detector
//   Receive-side sync timing recovery. Samples external h_sync/v_sync on the pixel
//   clock, recovers the pixel/line position, measures line and frame totals, and
//   declares lock after LOCK_FRAMES consecutive good frames.
//   Optional feature macro: VGA_DET_POLARITY_AUTO_EN (automatic sync polarity detect).
//   Without it, both syncs are taken as active-high and h_pol/v_pol stay 0.
module vga_sync_timing_detector #(
    parameter int COUNTER_SIZE = 11,
    parameter int EXP_H_TOTAL  = 1328,
    parameter int EXP_V_TOTAL  = 806,
    parameter int H_TOL        = 2,
    parameter int LOCK_FRAMES  = 2
) (
    input  logic                    control_clock,
    input  logic                    reset_n,
    input  logic                    h_sync,
    input  logic                    v_sync,
    output logic [COUNTER_SIZE-1:0] h_count,
    output logic [COUNTER_SIZE-1:0] v_count,
    output logic [COUNTER_SIZE-1:0] h_total_meas,
    output logic [COUNTER_SIZE-1:0] v_total_meas,
    output logic                    line_start,
    output logic                    frame_start,
    output logic                    locked,
    output logic                    timing_error,
    output logic                    h_pol,
    output logic                    v_pol
);
    localparam int            CS      = COUNTER_SIZE;
    localparam logic [CS-1:0] CNT_MAX = {CS{1'b1}};
    localparam logic [CS:0]   EXP_H   = (CS+1)'(EXP_H_TOTAL);
    localparam logic [CS:0]   EXP_V   = (CS+1)'(EXP_V_TOTAL);
    localparam logic [CS:0]   TOL_H   = (CS+1)'(H_TOL);
    localparam logic [3:0]    LOCK_N  = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {ST_SEARCH, ST_ACQUIRE, ST_LOCKED} state_t;

    // synchroniser (s1,s2) and edge register (s3) per sync input
    logic h_s1_q, h_s2_q, h_s3_q, h_s1_d, h_s2_d, h_s3_d;
    logic v_s1_q, v_s2_q, v_s3_q, v_s1_d, v_s2_d, v_s3_d;

    logic [CS-1:0] h_count_q, h_count_d, v_count_q, v_count_d;
    logic [CS-1:0] h_total_q, h_total_d, v_total_q, v_total_d;
    logic          line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic          timing_error_q, timing_error_d;
    logic          v_pend_q, v_pend_d;
    logic          bad_line_q, bad_line_d;
    state_t        state_q, state_d;
    logic [3:0]    good_cnt_q, good_cnt_d;

    logic          h_pol_cur, v_pol_cur, pol_change;
    logic          h_rise, v_rise;
    logic          line_start_w, frame_start_w, timeout_w, line_bad_w, frame_bad_w;
    logic [CS:0]   h_meas, v_meas, h_diff;

    // Synchroniser chain next values
    always_comb begin
        h_s1_d = h_sync;
        h_s2_d = h_s1_q;
        h_s3_d = h_s2_q;
        v_s1_d = v_sync;
        v_s2_d = v_s1_q;
        v_s3_d = v_s2_q;
    end

    // Polarity is applied to both taps so a polarity flip never fakes an edge
    assign h_rise = (h_s2_q ^ h_pol_cur) & ~(h_s3_q ^ h_pol_cur);
    assign v_rise = (v_s2_q ^ v_pol_cur) & ~(v_s3_q ^ v_pol_cur);

    // Position counters, measurements and line/frame quality
    always_comb begin
        line_start_w  = h_rise;
        frame_start_w = h_rise & (v_pend_q | v_rise);
        h_meas        = {1'b0, h_count_q} + (CS+1)'(1);
        v_meas        = {1'b0, v_count_q} + (CS+1)'(1);
        h_diff        = (h_meas >= EXP_H) ? (h_meas - EXP_H) : (EXP_H - h_meas);
        line_bad_w    = line_start_w & (h_diff > TOL_H);
        frame_bad_w   = frame_start_w & (bad_line_q | line_bad_w | (v_meas != EXP_V) |
                                         (v_count_q == CNT_MAX));
        timeout_w     = 1'b0;
        h_count_d     = h_count_q;
        v_count_d     = v_count_q;
        h_total_d     = h_total_q;
        v_total_d     = v_total_q;
        v_pend_d      = v_pend_q;
        bad_line_d    = bad_line_q;

        if (line_start_w) begin
            h_count_d = '0;
            h_total_d = h_meas[CS] ? CNT_MAX : h_meas[CS-1:0];
        end else if (h_count_q != CNT_MAX) begin
            h_count_d = h_count_q + CS'(1);
            timeout_w = (h_count_q == CNT_MAX - CS'(1));
        end

        if (frame_start_w) begin
            v_count_d = '0;
            v_total_d = v_meas[CS] ? CNT_MAX : v_meas[CS-1:0];
        end else if (line_start_w && v_count_q != CNT_MAX) begin
            v_count_d = v_count_q + CS'(1);
        end

        // a v edge waits for the next line start; extra v edges meanwhile collapse
        if (line_start_w)
            v_pend_d = 1'b0;
        else if (v_rise)
            v_pend_d = 1'b1;

        // the line ending at a frame start belongs to the frame that just closed
        if (frame_start_w)
            bad_line_d = 1'b0;
        else if (line_bad_w || timeout_w)
            bad_line_d = 1'b1;

        line_start_d  = line_start_w;
        frame_start_d = frame_start_w;
    end

`ifdef VGA_DET_POLARITY_AUTO_EN
    logic          h_pol_q, h_pol_d, v_pol_q, v_pol_d;
    logic          h_seen_q, h_seen_d, v_seen_q, v_seen_d;
    logic [CS-1:0] h_hi_q, h_hi_d, v_hi_q, v_hi_d;

    // Duty measurement: a sync high for more than half its period is active-low
    always_comb begin
        h_pol_d  = h_pol_q;
        v_pol_d  = v_pol_q;
        h_seen_d = h_seen_q | line_start_w;
        v_seen_d = v_seen_q | frame_start_w;
        h_hi_d   = h_hi_q;
        v_hi_d   = v_hi_q;
        if (line_start_w) begin
            h_hi_d = CS'(h_s2_q);
            if (h_seen_q)
                h_pol_d = ({1'b0, h_hi_q} > (h_meas >> 1));
        end else if (h_s2_q && h_hi_q != CNT_MAX) begin
            h_hi_d = h_hi_q + CS'(1);
        end
        if (frame_start_w) begin
            v_hi_d = CS'(v_s2_q);
            if (v_seen_q)
                v_pol_d = ({1'b0, v_hi_q} > (v_meas >> 1));
        end else if (line_start_w && v_s2_q && v_hi_q != CNT_MAX) begin
            v_hi_d = v_hi_q + CS'(1);
        end
    end

    // Polarity detector state
    always_ff @(posedge control_clock or negedge reset_n) begin
        if (!reset_n) begin
            h_pol_q  <= 1'b0;
            v_pol_q  <= 1'b0;
            h_seen_q <= 1'b0;
            v_seen_q <= 1'b0;
            h_hi_q   <= '0;
            v_hi_q   <= '0;
        end else begin
            h_pol_q  <= h_pol_d;
            v_pol_q  <= v_pol_d;
            h_seen_q <= h_seen_d;
            v_seen_q <= v_seen_d;
            h_hi_q   <= h_hi_d;
            v_hi_q   <= v_hi_d;
        end
    end

    assign h_pol_cur  = h_pol_q;
    assign v_pol_cur  = v_pol_q;
    assign pol_change = (h_pol_d != h_pol_q) | (v_pol_d != v_pol_q);
`else
    assign h_pol_cur  = 1'b0;
    assign v_pol_cur  = 1'b0;
    assign pol_change = 1'b0;
`endif

    // Lock FSM: next state, good-frame count and error pulse
    always_comb begin
        state_d        = state_q;
        good_cnt_d     = good_cnt_q;
        timing_error_d = 1'b0;
        unique case (state_q)
            ST_SEARCH: begin
                if (frame_start_w) begin
                    state_d    = ST_ACQUIRE;
                    good_cnt_d = '0;
                end
            end
            ST_ACQUIRE: begin
                if (frame_start_w) begin
                    if (frame_bad_w) begin
                        good_cnt_d = '0;
                    end else begin
                        good_cnt_d = good_cnt_q + 4'd1;
                        if (good_cnt_q + 4'd1 == LOCK_N)
                            state_d = ST_LOCKED;
                    end
                end else if (line_bad_w || timeout_w) begin
                    good_cnt_d = '0;
                end
            end
            ST_LOCKED: begin
                if (line_bad_w || frame_bad_w || timeout_w) begin
                    timing_error_d = 1'b1;
                    state_d        = ST_SEARCH;
                    good_cnt_d     = '0;
                end
            end
            default: begin
                state_d    = ST_SEARCH;
                good_cnt_d = '0;
            end
        endcase
        // a polarity flip invalidates every measurement taken so far
        if (pol_change) begin
            state_d        = ST_SEARCH;
            good_cnt_d     = '0;
            timing_error_d = (state_q == ST_LOCKED);
        end
    end

    // All detector state
    always_ff @(posedge control_clock or negedge reset_n) begin
        if (!reset_n) begin
            h_s1_q         <= 1'b0;
            h_s2_q         <= 1'b0;
            h_s3_q         <= 1'b0;
            v_s1_q         <= 1'b0;
            v_s2_q         <= 1'b0;
            v_s3_q         <= 1'b0;
            h_count_q      <= '0;
            v_count_q      <= '0;
            h_total_q      <= '0;
            v_total_q      <= '0;
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            timing_error_q <= 1'b0;
            v_pend_q       <= 1'b0;
            bad_line_q     <= 1'b0;
            state_q        <= ST_SEARCH;
            good_cnt_q     <= '0;
        end else begin
            h_s1_q         <= h_s1_d;
            h_s2_q         <= h_s2_d;
            h_s3_q         <= h_s3_d;
            v_s1_q         <= v_s1_d;
            v_s2_q         <= v_s2_d;
            v_s3_q         <= v_s3_d;
            h_count_q      <= h_count_d;
            v_count_q      <= v_count_d;
            h_total_q      <= h_total_d;
            v_total_q      <= v_total_d;
            line_start_q   <= line_start_d;
            frame_start_q  <= frame_start_d;
            timing_error_q <= timing_error_d;
            v_pend_q       <= v_pend_d;
            bad_line_q     <= bad_line_d;
            state_q        <= state_d;
            good_cnt_q     <= good_cnt_d;
        end
    end

    assign h_count      = h_count_q;
    assign v_count      = v_count_q;
    assign h_total_meas = h_total_q;
    assign v_total_meas = v_total_q;
    assign line_start   = line_start_q;
    assign frame_start  = frame_start_q;
    assign locked       = (state_q == ST_LOCKED);
    assign timing_error = timing_error_q;
    assign h_pol        = h_pol_cur;
    assign v_pol        = v_pol_cur;

endmodule
